// File: rtl/dispense_sequencer.sv
// dispense_sequencer: sequences one purchase through a shared dispense actuator.
// Tickets (codes 0..3) are offered first, then greedy change coins
// (codes 4..7 = 1, 5, 10, 50 yuan), one item per valid/ready transfer.
// Optional feature macro: CANCEL_REFUND_EN (cancel before the first ticket
// refunds refund_amt as coins instead of issuing tickets).
//
// Handshake: an item is transferred on a rising edge where act_valid and
// act_ready are both high. act_valid and act_code are decoded from state only,
// so they never depend on act_ready, and act_code is stable while an offer waits.
// Every offer is followed by one gap cycle with act_valid low.
module dispense_sequencer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic [1:0] ticket_type,
  input  logic [1:0] ticket_count,
  input  logic [7:0] change_amt,
  input  logic [7:0] refund_amt,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] tk_issued
);

  typedef enum logic [2:0] {
    S_IDLE, S_TICKET, S_TK_GAP, S_CHANGE, S_CH_GAP, S_DONE, S_FAULT
  } state_t;

  // state is left as a plain internal signal so checkers can bind to it.
  state_t     state, state_n;
  logic [1:0] type_q, type_n;
  logic [2:0] tk_left, tk_left_n;
  logic [7:0] remain, remain_n;
  logic [2:0] issued_n;
  logic [7:0] wait_cnt, wait_n;
  logic [2:0] coin_code;
  logic [7:0] coin_val;
  logic       offering, xfer, timed_out, cancel_refund;

  assign offering  = (state == S_TICKET) || (state == S_CHANGE);
  assign xfer      = offering & act_ready;
  assign timed_out = offering & ~act_ready & (wait_cnt == 8'(ACK_TIMEOUT - 1));

`ifdef CANCEL_REFUND_EN
  // Refund is only possible while no ticket has left the machine; a cancel
  // that coincides with a completed ticket transfer loses to the transfer.
  assign cancel_refund = cancel && (tk_issued == 3'd0) &&
                         (((state == S_TICKET) && !act_ready) || (state == S_TK_GAP));
`else
  assign cancel_refund = 1'b0;
  logic unused_refund;
  assign unused_refund = ^refund_amt;
`endif

  // Greedy coin choice for the current remainder; never exceeds remain.
  always_comb begin
    coin_code = 3'd4;
    coin_val  = 8'd1;
    if (remain >= 8'd50) begin
      coin_code = 3'd7;
      coin_val  = 8'd50;
    end else if (remain >= 8'd10) begin
      coin_code = 3'd6;
      coin_val  = 8'd10;
    end else if (remain >= 8'd5) begin
      coin_code = 3'd5;
      coin_val  = 8'd5;
    end
  end

  // Actuator offer and status flags decoded from the current state.
  always_comb begin
    act_valid = 1'b0;
    act_code  = 3'd0;
    case (state)
      S_TICKET: begin
        act_valid = 1'b1;
        act_code  = {1'b0, type_q};
      end
      S_CHANGE: begin
        act_valid = 1'b1;
        act_code  = coin_code;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign fault = (state == S_FAULT);

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_n   = state;
    type_n    = type_q;
    tk_left_n = tk_left;
    remain_n  = remain;
    issued_n  = tk_issued;
    wait_n    = wait_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          type_n    = ticket_type;
          tk_left_n = {1'b0, ticket_count} + 3'd1;
          remain_n  = change_amt;
          issued_n  = 3'd0;
          wait_n    = 8'd0;
          state_n   = S_TICKET;
        end
      end
      S_TICKET: begin
        if (xfer) begin
          tk_left_n = tk_left - 3'd1;
          issued_n  = tk_issued + 3'd1;
          state_n   = S_TK_GAP;
        end else if (cancel_refund) begin
          // Withdraw the offer through the change gap so act_valid drops
          // for a cycle before the refund coins (or DONE) follow.
          remain_n  = refund_amt;
          tk_left_n = 3'd0;
          state_n   = S_CH_GAP;
        end else if (timed_out) begin
          state_n = S_FAULT;
        end else if (!act_ready) begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      S_TK_GAP: begin
        wait_n = 8'd0;
        if (cancel_refund) begin
          remain_n  = refund_amt;
          tk_left_n = 3'd0;
          state_n   = S_CH_GAP;
        end else if (tk_left != 3'd0) begin
          state_n = S_TICKET;
        end else if (remain != 8'd0) begin
          state_n = S_CHANGE;
        end else begin
          state_n = S_DONE;
        end
      end
      S_CHANGE: begin
        if (xfer) begin
          remain_n = remain - coin_val;
          state_n  = S_CH_GAP;
        end else if (timed_out) begin
          state_n = S_FAULT;
        end else if (!act_ready) begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      S_CH_GAP: begin
        wait_n = 8'd0;
        if (remain != 8'd0) state_n = S_CHANGE;
        else                state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      S_FAULT: begin
        if (cancel) begin
          issued_n = 3'd0;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any item in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      type_q    <= 2'd0;
      tk_left   <= 3'd0;
      remain    <= 8'd0;
      tk_issued <= 3'd0;
      wait_cnt  <= 8'd0;
    end else begin
      state     <= state_n;
      type_q    <= type_n;
      tk_left   <= tk_left_n;
      remain    <= remain_n;
      tk_issued <= issued_n;
      wait_cnt  <= wait_n;
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer: a vector table, hand-written
// corner sequences and randomized purchases, all scored against a queue of
// expected actuator codes derived from the ticket/greedy-change rules.
module tb_dispense_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, cancel = 1'b0, act_ready = 1'b0;
  logic [1:0] ticket_type = 2'd0, ticket_count = 2'd0;
  logic [7:0] change_amt = 8'd0, refund_amt = 8'd0;
  logic       act_valid, busy, done, fault;
  logic [2:0] act_code, tk_issued;

  always #5 clk = ~clk;

  dispense_sequencer #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel),
    .ticket_type(ticket_type), .ticket_count(ticket_count),
    .change_amt(change_amt), .refund_amt(refund_amt), .act_ready(act_ready),
    .act_valid(act_valid), .act_code(act_code), .busy(busy), .done(done),
    .fault(fault), .tk_issued(tk_issued)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: tickets first, then coins chosen largest-first.
  task automatic model_coins(input int amount);
    int r = amount;
    while (r > 0) begin
      if (r >= 50)      begin exp_q.push_back(3'd7); r -= 50; end
      else if (r >= 10) begin exp_q.push_back(3'd6); r -= 10; end
      else if (r >= 5)  begin exp_q.push_back(3'd5); r -= 5;  end
      else              begin exp_q.push_back(3'd4); r -= 1;  end
    end
  endtask

  task automatic model_fill(input logic [1:0] typ, input int cnt, input int chg);
    for (int i = 0; i <= cnt; i++) exp_q.push_back({1'b0, typ});
    model_coins(chg);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_purchase(input logic [1:0] typ, input logic [1:0] cnt,
                                input logic [7:0] chg, input logic [7:0] refund);
    ticket_type  = typ;
    ticket_count = cnt;
    change_amt   = chg;
    refund_amt   = refund;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("start_latency_valid", act_valid, 1);
    check("start_tk_issued_zero", tk_issued, 0);
  endtask

  // Runs the actuator side until done; ready is withheld hold cycles per item.
  // cancel_item >= 0 pulses cancel during the offer of that item index.
  task automatic collect(input string name, input int hold_lo, input int hold_hi,
                         input int cancel_item, input bit noise,
                         input logic [2:0] exp_tk, output int items);
    int   waited = 0, gap = 0;
    int   hold;
    bit   fin = 0, cancelled = 0, was_valid = 0, prev_wait = 0;
    logic [2:0] prev_code = 3'd0;
    logic [2:0] exp_code;
    items = 0;
    hold  = $urandom_range(hold_hi, hold_lo);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      cancel = 1'b0;
      start  = 1'b0;
      if (act_valid && items == cancel_item && !cancelled) begin
        cancel    = 1'b1;
        act_ready = 1'b0;
        cancelled = 1;
      end else begin
        act_ready = act_valid && (waited >= hold);
      end
      if (noise && $urandom_range(7, 0) == 0) begin
        start        = 1'b1;
        ticket_type  = 2'($urandom_range(3, 0));
        ticket_count = 2'($urandom_range(3, 0));
        change_amt   = 8'($urandom_range(255, 0));
      end
      @(negedge clk);
      if (act_valid) begin
        if (prev_wait) check({name, "_code_stable"}, act_code, prev_code);
        if (!was_valid && items > 0) check({name, "_gap_len"}, gap, 1);
        gap = 0;
        if (act_ready) begin
          exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
          check({name, "_code"}, act_code, exp_code);
          items++;
          waited = 0;
          hold   = $urandom_range(hold_hi, hold_lo);
        end else begin
          waited++;
        end
      end else if (done) begin
        check({name, "_tk_issued"}, tk_issued, exp_tk);
        check({name, "_all_items_seen"}, exp_q.size(), 0);
        fin = 1;
      end else begin
        gap++;
      end
      was_valid = act_valid;
      prev_wait = act_valid && !act_ready;
      prev_code = act_code;
      tick();
    end
    cancel    = 1'b0;
    start     = 1'b0;
    act_ready = 1'b0;
    check({name, "_finished_in_budget"}, fin, 1);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_busy_low_after"}, busy, 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_act_valid"}, act_valid, 0);
    check({name, "_act_code"}, act_code, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_fault"}, fault, 0);
    check({name, "_tk_issued"}, tk_issued, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] typ;
    logic [1:0] cnt;
    logic [7:0] chg;
    int         hold;
    int         cancel_item;
    int         exp_items;
    logic [2:0] exp_tk;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int vcnt;
    logic [1:0] rt, rc;
    logic [7:0] rchg;

    vecs[0] = '{typ: 2'd2, cnt: 2'd1, chg: 8'd17,  hold: 0, cancel_item: -1, exp_items: 6,  exp_tk: 3'd2};
    vecs[1] = '{typ: 2'd0, cnt: 2'd0, chg: 8'd0,   hold: 0, cancel_item: -1, exp_items: 1,  exp_tk: 3'd1};
    vecs[2] = '{typ: 2'd3, cnt: 2'd0, chg: 8'd255, hold: 3, cancel_item: -1, exp_items: 7,  exp_tk: 3'd1};
    vecs[3] = '{typ: 2'd1, cnt: 2'd2, chg: 8'd99,  hold: 1, cancel_item: -1, exp_items: 13, exp_tk: 3'd3};
    vecs[4] = '{typ: 2'd3, cnt: 2'd3, chg: 8'd4,   hold: 2, cancel_item: -1, exp_items: 8,  exp_tk: 3'd4};
    vecs[5] = '{typ: 2'd2, cnt: 2'd0, chg: 8'd50,  hold: 0, cancel_item: 1,  exp_items: 2,  exp_tk: 3'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Cancel in IDLE does nothing
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("idle_cancel_busy", busy, 0);

    // Hand sequence: literal code list for 2 tickets of type 2 plus 17 yuan
    exp_q = '{3'd2, 3'd2, 3'd6, 3'd5, 3'd4, 3'd4};
    start_purchase(2'd2, 2'd1, 8'd17, 8'd0);
    collect("lit17", 0, 0, -1, 0, 3'd2, n);
    check("lit17_items", n, 6);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      model_fill(vecs[i].typ, vecs[i].cnt, vecs[i].chg);
      start_purchase(vecs[i].typ, vecs[i].cnt, vecs[i].chg, 8'd0);
      collect($sformatf("vec%0d", i), vecs[i].hold, vecs[i].hold,
              vecs[i].cancel_item, 0, vecs[i].exp_tk, n);
      check($sformatf("vec%0d_items", i), n, vecs[i].exp_items);
    end

`ifdef CANCEL_REFUND_EN
    // Cancel during the first ticket offer refunds 60 yuan as 50 + 10
    exp_q = '{3'd7, 3'd6};
    start_purchase(2'd0, 2'd2, 8'd3, 8'd60);
    collect("refund", 0, 0, 0, 0, 3'd0, n);
    check("refund_items", n, 2);
    // Same cancel after one ticket is ignored
    exp_q = '{3'd0, 3'd0, 3'd5};
    start_purchase(2'd0, 2'd1, 8'd5, 8'd60);
    collect("late_cancel", 0, 0, 1, 0, 3'd2, n);
    check("late_cancel_items", n, 3);
`else
    // Cancel during the first ticket offer is ignored
    exp_q = '{3'd0, 3'd0, 3'd5};
    start_purchase(2'd0, 2'd1, 8'd5, 8'd60);
    collect("cancel_ignored", 0, 0, 0, 0, 3'd2, n);
    check("cancel_ignored_items", n, 3);
`endif

    // Timeout: one ticket goes, the second offer is never accepted
    start_purchase(2'd1, 2'd1, 8'd0, 8'd0);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    tick();
    vcnt = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      @(negedge clk);
      if (act_valid) vcnt++;
      tick();
    end
    check("timeout_wait_cycles", vcnt, 16);
    check("timeout_fault", fault, 1);
    check("timeout_valid_low", act_valid, 0);
    check("timeout_tk_issued", tk_issued, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("fault_start_ignored", fault, 1);
    check("fault_start_ignored_valid", act_valid, 0);
    check("fault_busy", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("fault_cancel_clear", fault, 0);
    check("fault_cancel_idle", busy, 0);
    check("fault_cancel_tk_issued", tk_issued, 0);

    // Async reset while a coin is offered
    start_purchase(2'd0, 2'd0, 8'd255, 8'd0);
    for (int i = 0; i < 20 && !(act_valid && act_code[2]); i++) begin
      act_ready = act_valid;
      tick();
    end
    act_ready = 1'b1;
    @(negedge clk);
    check("pre_reset_coin_offer", act_valid & act_code[2], 1);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    act_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model_fill(2'd3, 1, 36);
    start_purchase(2'd3, 2'd1, 8'd36, 8'd0);
    collect("post_reset", 0, 1, -1, 0, 3'd2, n);

    // Randomized purchases with input noise while busy
    for (int k = 0; k < 20; k++) begin
      rt   = 2'($urandom_range(3, 0));
      rc   = 2'($urandom_range(3, 0));
      rchg = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 0));
      model_fill(rt, rc, rchg);
      start_purchase(rt, rc, rchg, 8'($urandom_range(255, 0)));
      collect($sformatf("rand%0d", k), 0, 3, -1, 1, 3'(rc) + 3'd1, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
